instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the 16-bit CPU; sits directly upstream of the unified memory and drives its address port.
- Keeps the program counter and reads one word per cycle from memory's combinational read path.
- Buffers fetched words, tagged with their PC, in a small FIFO and hands them to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump) with buffer flush.

Parameters:
N, 10, address width; PC wraps modulo 2^N
M, 16, instruction word width
DEPTH, 2, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
fetch_en  input  1  1 = fetching permitted this cycle
mem_address  output  N  address to memory; combinationally equals pc register
mem_WE  output  1  memory write enable; tied 0
mem_readData  input  M  memory read data; combinational function of mem_address, valid same cycle
redirect  input  1  1 = load redirect_pc and flush FIFO at this edge
redirect_pc  input  N  new PC on redirect
instr  output  M  FIFO head instruction word
instr_pc  output  N  PC of FIFO head
instr_valid  output  1  FIFO non-empty
instr_ready  input  1  decode accepts head this cycle
fifo_count  output  clog2(DEPTH)+1  current occupancy, for debug and verification

Behaviour:
- Reset (async, any time, including mid-stream):
  - pc=RESET_PC, FIFO emptied, fifo_count=0, instr_valid=0.
  - instr and instr_pc read 0 while empty.
  - mem_WE=0 always.
- pop = instr_valid & instr_ready.
- push = fetch_en & !redirect & (fifo_count<DEPTH | pop). Push is allowed when full if a pop happens in the same cycle.
- Push edge:
  - FIFO tail <= {pc, mem_readData}.
  - pc <= pc+1 mod 2^N; 2^N-1 wraps to 0.
- Pop edge: head advances.
- fifo_count update:
  - +1 on push only; -1 on pop only; unchanged on push+pop.
  - Never exceeds DEPTH; never goes below 0.
- Redirect:
  - Highest priority at the edge: FIFO flushed to count 0, pc <= redirect_pc, no push.
  - A pop in the same cycle is taken by decode. That word is considered consumed, but it is flushed from the FIFO.
  - The first word from redirect_pc is pushed at the following edge.
- Latency:
  - Memory read has zero latency; the word is captured at the edge ending the cycle in which pc is presented.
  - After reset deassert, or after redirect, instr_valid rises one edge later if fetch_en=1.
- fetch_en=0: pc holds, no push; pops continue.
- Full FIFO with no pop: pc holds, mem_address stable, no push.
- Ordering: words leave in PC order. instr_pc of consecutive words differs by +1 mod 2^N unless a redirect occurred.
- Throughput: with instr_ready held at 1, one instruction per cycle sustained.
- The FIFO is implemented with head/tail pointers mod DEPTH plus a count register. A shift register is not used.
- No combinational path from instr_ready to mem_address. There is a path from instr_ready to push, but the push only qualifies a register update.

Test Plan:
- Reset then sequential fetch: memory word[i]=16'hA000+i, fetch_en=1, instr_ready=1. Result: instr_valid from the first edge; instr/instr_pc = A000/0, A001/1, A002/2 on consecutive cycles; fifo_count stays 1.
- Backpressure fill: instr_ready=0 for 5 cycles from reset. Result: fifo_count 1 then 2, held at 2; mem_address stuck at 2. Raise instr_ready: words 0,1,2,3 emerge in order with no gaps or duplicates.
- Redirect with full FIFO: FIFO holds pc 4,5; assert redirect with redirect_pc=10'h3F0 for 1 cycle. Result: next cycle fifo_count=0, instr_valid=0, mem_address=3F0. The following cycle instr_pc=3F0, instr=word[3F0].
- Wrap-around: redirect_pc=10'h3FE with free-running fetch. Result: instr_pc sequence 3FE, 3FF, 000, 001.
- fetch_en gating and simultaneous push/pop at full: FIFO full with fetch_en=1 and instr_ready=1 for 1 cycle. Result: count stays 2, one pop and one push. Then fetch_en=0 with drain. Result: count falls 2, 1, 0; pc unchanged.
- Async reset mid-stream: assert reset between edges with count=2. Result: instr_valid=0, fifo_count=0, mem_address=RESET_PC immediately without waiting for clk; normal fetch resumes after deassert.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: program counter, zero-latency memory read and a
// PC-tagged prefetch FIFO that feeds decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int N = 10,
  parameter int M = 16,
  parameter int DEPTH = 2,
  parameter logic [N-1:0] RESET_PC = {N{1'b0}}
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  output logic [N-1:0]             mem_address,
  output logic                     mem_WE,
  input  logic [M-1:0]             mem_readData,
  input  logic                     redirect,
  input  logic [N-1:0]             redirect_pc,
  output logic [M-1:0]             instr,
  output logic [N-1:0]             instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [N-1:0]  pc_r;
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic [M-1:0]  word_mem_r [DEPTH];
  logic [N-1:0]  pc_mem_r [DEPTH];
  logic          pop_s;
  logic          push_s;

  assign mem_address = pc_r;
  assign mem_WE      = 1'b0;
  assign fifo_count  = count_r;
  assign instr_valid = (count_r != {CW{1'b0}});
  assign pop_s       = instr_valid & instr_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_s      = fetch_en & ~redirect & ((count_r < CW'(DEPTH)) | pop_s);

  // Occupancy update for the push/pop combinations.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      2'b11:   count_next_s = count_r;
      default: count_next_s = count_r;
    endcase
  end

  // Head presentation; reads zero while the FIFO is empty.
  always_comb begin
    instr    = {M{1'b0}};
    instr_pc = {N{1'b0}};
    if (instr_valid) begin
      instr    = word_mem_r[head_r];
      instr_pc = pc_mem_r[head_r];
    end else begin
      instr    = {M{1'b0}};
      instr_pc = {N{1'b0}};
    end
  end

  // PC, FIFO pointers, occupancy and storage; redirect flushes and wins over push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r    <= RESET_PC;
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        word_mem_r[i] <= {M{1'b0}};
        pc_mem_r[i]   <= {N{1'b0}};
      end
    end else if (redirect) begin
      pc_r    <= redirect_pc;
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        word_mem_r[tail_r] <= mem_readData;
        pc_mem_r[tail_r]   <= pc_r;
        tail_r             <= tail_r + AW'(1);
        pc_r               <= pc_r + N'(1);
      end
      if (pop_s) begin
        head_r <= head_r + AW'(1);
      end
      count_r <= count_next_s;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector tables from the test
// plan, an async mid-stream reset, and random traffic against a queue model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [9:0]  mem_address;
  logic        mem_WE;
  logic [15:0] mem_readData;
  logic        redirect;
  logic [9:0]  redirect_pc;
  logic [15:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit #(.N(10), .M(16), .DEPTH(2), .RESET_PC(10'h000)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .mem_address(mem_address),
    .mem_WE(mem_WE), .mem_readData(mem_readData), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input logic [9:0] a);
    return 16'hA000 + {6'b000000, a};
  endfunction

  // Combinational memory: word[i] = A000 + i.
  assign mem_readData = word_of(mem_address);

  // Reference model: a queue of {pc, word} entries plus the program counter.
  typedef struct {
    logic [9:0]  pc;
    logic [15:0] w;
  } ent_t;
  ent_t       mq[$];
  logic [9:0] mpc;

  typedef struct {
    logic       fen;
    logic       rdy;
    logic       red;
    logic [9:0] rpc;
    int         ecount;
    logic [9:0] eipc;
    logic [9:0] eaddr;
  } vec_t;
  vec_t tbl_a[$];
  vec_t tbl_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc = 10'h000;
  endtask

  task automatic check_model();
    chk("m_addr", {22'd0, mem_address}, {22'd0, mpc});
    chk("m_we", {31'd0, mem_WE}, 32'd0);
    chk("m_count", {30'd0, fifo_count}, mq.size());
    chk("m_valid", {31'd0, instr_valid}, {31'd0, (mq.size() != 0)});
    if (mq.size() != 0) begin
      chk("m_ipc", {22'd0, instr_pc}, {22'd0, mq[0].pc});
      chk("m_instr", {16'd0, instr}, {16'd0, mq[0].w});
    end else begin
      chk("m_ipc0", {22'd0, instr_pc}, 32'd0);
      chk("m_instr0", {16'd0, instr}, 32'd0);
    end
  endtask

  task automatic model_edge(input logic fen, input logic rdy, input logic red, input logic [9:0] rpc);
    bit pop;
    bit push;
    pop  = (mq.size() != 0) && rdy;
    push = fen && !red && ((mq.size() < 2) || pop);
    if (red) begin
      mq.delete();
      mpc = rpc;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{pc: mpc, w: word_of(mpc)});
        mpc = mpc + 10'd1;
      end
    end
  endtask

  // Drive one cycle: inputs just after an edge, compare mid-cycle, then clock.
  task automatic run_cycle(input logic fen, input logic rdy, input logic red, input logic [9:0] rpc,
                           input bit use_tbl, input int ecount, input logic [9:0] eipc,
                           input logic [9:0] eaddr);
    fetch_en    = fen;
    instr_ready = rdy;
    redirect    = red;
    redirect_pc = rpc;
    #3;
    check_model();
    if (use_tbl) begin
      chk("t_count", {30'd0, fifo_count}, ecount);
      chk("t_addr", {22'd0, mem_address}, {22'd0, eaddr});
      chk("t_valid", {31'd0, instr_valid}, {31'd0, (ecount != 0)});
      chk("t_ipc", {22'd0, instr_pc}, (ecount != 0) ? {22'd0, eipc} : 32'd0);
      chk("t_instr", {16'd0, instr}, (ecount != 0) ? {16'd0, word_of(eipc)} : 32'd0);
    end
    @(posedge clk);
    model_edge(fen, rdy, red, rpc);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_count", {30'd0, fifo_count}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_addr", {22'd0, mem_address}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    fetch_en    = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 10'h000;
    model_reset();

    // Sequential fetch from reset: {fen, rdy, red, rpc, count, head pc, address}.
    tbl_a.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 0, 10'h000, 10'h000});
    tbl_a.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 1, 10'h000, 10'h001});
    tbl_a.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 1, 10'h001, 10'h002});
    tbl_a.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 1, 10'h002, 10'h003});

    // Backpressure fill, drain, redirect at full, wrap, push+pop at full, fetch_en drain.
    tbl_b.push_back('{1'b1, 1'b0, 1'b0, 10'h000, 0, 10'h000, 10'h000});
    tbl_b.push_back('{1'b1, 1'b0, 1'b0, 10'h000, 1, 10'h000, 10'h001});
    tbl_b.push_back('{1'b1, 1'b0, 1'b0, 10'h000, 2, 10'h000, 10'h002});
    tbl_b.push_back('{1'b1, 1'b0, 1'b0, 10'h000, 2, 10'h000, 10'h002});
    tbl_b.push_back('{1'b1, 1'b0, 1'b0, 10'h000, 2, 10'h000, 10'h002});
    tbl_b.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 2, 10'h000, 10'h002});
    tbl_b.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 2, 10'h001, 10'h003});
    tbl_b.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 2, 10'h002, 10'h004});
    tbl_b.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 2, 10'h003, 10'h005});
    tbl_b.push_back('{1'b1, 1'b0, 1'b1, 10'h3F0, 2, 10'h004, 10'h006});
    tbl_b.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 0, 10'h000, 10'h3F0});
    tbl_b.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 1, 10'h3F0, 10'h3F1});
    tbl_b.push_back('{1'b1, 1'b1, 1'b1, 10'h3FE, 1, 10'h3F1, 10'h3F2});
    tbl_b.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 0, 10'h000, 10'h3FE});
    tbl_b.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 1, 10'h3FE, 10'h3FF});
    tbl_b.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 1, 10'h3FF, 10'h000});
    tbl_b.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 1, 10'h000, 10'h001});
    tbl_b.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 1, 10'h001, 10'h002});
    tbl_b.push_back('{1'b1, 1'b0, 1'b0, 10'h000, 1, 10'h002, 10'h003});
    tbl_b.push_back('{1'b1, 1'b1, 1'b0, 10'h000, 2, 10'h002, 10'h004});
    tbl_b.push_back('{1'b0, 1'b1, 1'b0, 10'h000, 2, 10'h003, 10'h005});
    tbl_b.push_back('{1'b0, 1'b1, 1'b0, 10'h000, 1, 10'h004, 10'h005});
    tbl_b.push_back('{1'b0, 1'b0, 1'b0, 10'h000, 0, 10'h000, 10'h005});

    repeat (2) @(posedge clk);
    #1;
    do_reset();
    foreach (tbl_a[i])
      run_cycle(tbl_a[i].fen, tbl_a[i].rdy, tbl_a[i].red, tbl_a[i].rpc, 1'b1,
                tbl_a[i].ecount, tbl_a[i].eipc, tbl_a[i].eaddr);

    do_reset();
    foreach (tbl_b[i])
      run_cycle(tbl_b[i].fen, tbl_b[i].rdy, tbl_b[i].red, tbl_b[i].rpc, 1'b1,
                tbl_b[i].ecount, tbl_b[i].eipc, tbl_b[i].eaddr);

    // Async reset between edges with a full FIFO, then normal fetch resumes.
    run_cycle(1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 0, 10'h000, 10'h000);
    run_cycle(1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 0, 10'h000, 10'h000);
    run_cycle(1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 0, 10'h000, 10'h000);
    chk("pre_rst_full", {30'd0, fifo_count}, 32'd2);
    #2;
    do_reset();
    for (int i = 0; i < 4; i++)
      run_cycle(1'b1, 1'b1, 1'b0, 10'h000, 1'b1, (i == 0) ? 0 : 1, 10'(i - 1), 10'(i));

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      logic fen;
      logic rdy;
      logic red;
      logic [9:0] rpc;
      fen = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      red = ($urandom_range(0, 11) == 0);
      rpc = 10'($urandom_range(0, 1023));
      run_cycle(fen, rdy, red, rpc, 1'b0, 0, 10'h000, 10'h000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
